// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Framing stage behind the UART receiver. It hunts for a start-of-frame
// marker, then collects the length byte, the payload and the checksum.
// The payload is held in a local buffer and replayed on a valid/ready
// stream only after the checksum verifies, so a corrupt frame never
// reaches the consumer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_HUNT    | idle, waiting for SOF; other bytes and rx errors ignored
// S_LEN     | SOF seen, next byte is payload length (1..MAX_LEN)
// S_PAYLOAD | storing payload bytes into the buffer, accumulating sum
// S_CSUM    | next byte is checksum; zero total releases the frame
// S_DRAIN   | replaying buffered payload; incoming bytes are dropped
module uart_frame_parser #(
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_error,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic [7:0]      buf_q [MAX_LEN];
  logic            buf_we;

  logic [7:0]      len_last;
  logic [7:0]      csum_total;
  logic            byte_ok;
  logic            xfer;

  // A byte arriving together with an rx error is treated as corrupt.
  assign byte_ok    = in_valid & ~in_error;
  assign len_last   = len_q - 8'd1;
  assign csum_total = sum_q + in_data;

  // Stream outputs decode only from registered state and read pointer.
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = out_valid && (8'(rd_ptr_q) == len_last);
  assign out_data  = out_valid ? buf_q[rd_ptr_q] : 8'h00;
  assign xfer      = out_valid & out_ready;

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_HUNT);

  // Next-state, datapath updates and status pulse decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (byte_ok && (in_data == SOF)) begin
          state_d  = S_LEN;
          sum_d    = 8'h00;
          wr_ptr_d = '0;
        end
      end

      S_LEN: begin
        if (in_error) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end else if (in_valid) begin
          if ((in_data == 8'h00) || (in_data > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            len_d   = in_data;
            sum_d   = in_data;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (in_error) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end else if (in_valid) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          sum_d    = sum_q + in_data;
          if (8'(wr_ptr_q) == len_last) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (in_error) begin
          frame_err_d = 1'b1;
          state_d     = S_HUNT;
        end else if (in_valid) begin
          if (csum_total == 8'h00) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = '0;
            state_d    = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end
        end
      end

      S_DRAIN: begin
        // SOF detection is suspended here; any byte is simply lost.
        if (byte_ok) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          if (out_last) begin
            rd_ptr_d = '0;
            state_d  = S_HUNT;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // State, pointers, sum and status pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= 8'h00;
      sum_q       <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Payload storage; contents are only meaningful once a frame verifies.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limits,
// rx error abort, backpressure with overrun, and reset during drain.
module tb_uart_frame_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_error;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  int n_ok   = 0;
  int n_err  = 0;
  int n_ovr  = 0;
  int n_both = 0;
  logic [7:0] stream_q [$];
  logic       last_q   [$];

  uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_error  (in_error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and accepted-stream capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_ok) n_ok++;
    if (frame_err) n_err++;
    if (overrun) n_ovr++;
    if (frame_ok && frame_err) n_both++;
    if (out_valid && out_ready) begin
      stream_q.push_back(out_data);
      last_q.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_good3();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok0, err0, ovr0, s0;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_error = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 8'h00);
    check("rst_out_last",  out_last, 0);
    check("rst_busy",      busy, 0);
    check("rst_flags",     {frame_ok, frame_err, overrun}, 0);
    rst_n = 1'b1;
    tick();

    // Good frame, consumer always ready.
    ok0 = n_ok; err0 = n_err; s0 = stream_q.size();
    send(8'hA5);
    check("busy_after_sof", busy, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    check("g1_frame_ok", frame_ok, 1);
    check("g1_valid0",   out_valid, 1);
    check("g1_data0",    out_data, 8'h11);
    check("g1_last0",    out_last, 0);
    tick();
    check("g1_ok_pulse", frame_ok, 0);
    check("g1_data1",    out_data, 8'h22);
    tick();
    check("g1_data2",    out_data, 8'h33);
    check("g1_last2",    out_last, 1);
    tick();
    check("g1_valid_end", out_valid, 0);
    check("g1_busy_end",  busy, 0);
    tick();
    check("g1_ok_count",  n_ok - ok0, 1);
    check("g1_err_count", n_err - err0, 0);
    check("g1_nbytes",    stream_q.size() - s0, 3);
    check("g1_s0", stream_q[s0],   8'h11);
    check("g1_s1", stream_q[s0+1], 8'h22);
    check("g1_s2", stream_q[s0+2], 8'h33);
    check("g1_l",  {last_q[s0], last_q[s0+1], last_q[s0+2]}, 3'b001);

    // Bad checksum.
    ok0 = n_ok; err0 = n_err; s0 = stream_q.size();
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
    check("bad_cs_err",   frame_err, 1);
    check("bad_cs_valid", out_valid, 0);
    check("bad_cs_busy",  busy, 0);
    tick(); tick();
    check("bad_cs_ok_count",  n_ok - ok0, 0);
    check("bad_cs_err_count", n_err - err0, 1);
    check("bad_cs_nbytes",    stream_q.size() - s0, 0);
    send_good3();
    check("after_bad_ok", frame_ok, 1);
    tick(); tick(); tick();
    check("after_bad_idle", out_valid, 0);

    // Noise and rx error in HUNT are ignored; bad lengths rejected.
    err0 = n_err;
    send(8'h00); send(8'hFF); send(8'h5A);
    in_error = 1'b1; tick(); in_error = 1'b0;
    check("noise_busy", busy, 0);
    tick();
    check("noise_no_err", n_err - err0, 0);
    send(8'hA5); send(8'h00);
    check("len0_err",  frame_err, 1);
    check("len0_busy", busy, 0);
    send(8'hA5); send(8'h11);
    check("len17_err", frame_err, 1);
    check("len17_busy", busy, 0);

    // Maximum length frame: payload 01..10, checksum 68.
    ok0 = n_ok; s0 = stream_q.size();
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h68);
    check("len16_ok", frame_ok, 1);
    for (int i = 0; i < 16; i++) tick();
    check("len16_done", out_valid, 0);
    check("len16_nbytes", stream_q.size() - s0, 16);
    for (int i = 0; i < 16; i++) check("len16_byte", stream_q[s0+i], 8'(i + 1));
    check("len16_last", last_q[s0+15], 1);
    check("len16_last_early", last_q[s0+14], 0);

    // Receiver error mid-payload aborts; next frame is fine.
    send(8'hA5); send(8'h02); send(8'h44);
    in_error = 1'b1; tick(); in_error = 1'b0;
    check("rxerr_err",  frame_err, 1);
    check("rxerr_busy", busy, 0);
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    check("one_ok",   frame_ok, 1);
    check("one_data", out_data, 8'h7F);
    check("one_last", out_last, 1);
    tick();
    check("one_done", out_valid, 0);

    // Backpressure with an overrun byte while draining.
    ovr0 = n_ovr; s0 = stream_q.size();
    out_ready = 1'b0;
    send_good3();
    check("bp_ok", frame_ok, 1);
    tick(); tick();
    check("bp_hold_data", out_data, 8'h11);
    check("bp_hold_last", out_last, 0);
    send(8'hC3);
    check("bp_overrun",  overrun, 1);
    check("bp_data_ovr", out_data, 8'h11);
    tick(); tick();
    check("bp_overrun_pulse", overrun, 0);
    check("bp_still_valid", out_valid, 1);
    check("bp_still_data",  out_data, 8'h11);
    out_ready = 1'b1;
    tick();
    check("bp_data1", out_data, 8'h22);
    tick();
    check("bp_data2", out_data, 8'h33);
    tick();
    check("bp_done", out_valid, 0);
    tick();
    check("bp_ovr_count", n_ovr - ovr0, 1);
    check("bp_nbytes", stream_q.size() - s0, 3);
    check("bp_s0", stream_q[s0],   8'h11);
    check("bp_s2", stream_q[s0+2], 8'h33);

    // Reset asserted while draining.
    out_ready = 1'b0;
    send_good3();
    check("rd_valid_pre", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rd_valid", out_valid, 0);
    check("rd_data",  out_data, 8'h00);
    check("rd_busy",  busy, 0);
    check("rd_flags", {frame_ok, frame_err, overrun, out_last}, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_good3();
    check("rd_after_ok",   frame_ok, 1);
    check("rd_after_data", out_data, 8'h11);
    tick(); tick(); tick();
    check("rd_after_done", out_valid, 0);

    check("ok_err_exclusive", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
